// File: rtl/dragon_hit_judge.sv
// dragon_hit_judge: player projectile, dragon hit test, kill request and kill score.
// Ports: clk_22/rst, fire, p_x/p_y, d_x/d_y, show_valid -> life_state, b_x/b_y, b_valid, score.
module dragon_hit_judge #(
    parameter int unsigned BULLET_STEP = 8,
    parameter int unsigned BULLET_W    = 8,
    parameter int unsigned BULLET_H    = 4,
    parameter int unsigned DRAGON_W    = 40,
    parameter int unsigned DRAGON_H    = 40,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned HOLD_MAX    = 15,
    parameter int unsigned SCORE_MAX   = 999
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic       fire,
    input  logic [9:0] p_x,
    input  logic [9:0] p_y,
    input  logic [9:0] d_x,
    input  logic [9:0] d_y,
    input  logic       show_valid,
    output logic       life_state,
    output logic [9:0] b_x,
    output logic [9:0] b_y,
    output logic       b_valid,
    output logic [9:0] score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    localparam logic [10:0] BW11  = 11'(BULLET_W);
    localparam logic [10:0] BH11  = 11'(BULLET_H);
    localparam logic [10:0] DW11  = 11'(DRAGON_W);
    localparam logic [10:0] DH11  = 11'(DRAGON_H);
    localparam logic [10:0] XLIM  = 11'(SCREEN_W - BULLET_STEP);
    localparam logic [9:0]  STEP  = 10'(BULLET_STEP);
    localparam logic [9:0]  SMAX  = 10'(SCORE_MAX);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

    logic [1:0]    state_q, state_d;
    logic          fire_q;
    logic          life_q, life_d;
    logic          bvalid_q, bvalid_d;
    logic [9:0]    bx_q, bx_d;
    logic [9:0]    by_q, by_d;
    logic [9:0]    score_q, score_d;
    logic [HW-1:0] hold_q, hold_d;

    logic        fire_rise;
    logic        overlap;
    logic [10:0] bx_e, by_e, dx_e, dy_e;

    assign fire_rise = fire & ~fire_q;

    // Widen to 11 bits so box edges near 1023 never wrap.
    assign bx_e = {1'b0, bx_q};
    assign by_e = {1'b0, by_q};
    assign dx_e = {1'b0, d_x};
    assign dy_e = {1'b0, d_y};

    // Strict compares: boxes that only touch do not overlap.
    assign overlap = (bx_e < dx_e + DW11) && (bx_e + BW11 > dx_e) &&
                     (by_e < dy_e + DH11) && (by_e + BH11 > dy_e);

    always_comb begin
        state_d  = state_q;
        life_d   = life_q;
        bvalid_d = bvalid_q;
        bx_d     = bx_q;
        by_d     = by_q;
        score_d  = score_q;
        hold_d   = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire_rise) begin
                    bx_d     = p_x;
                    by_d     = p_y;
                    bvalid_d = 1'b1;
                    state_d  = S_FLY;
                end
            end
            S_FLY: begin
                if (overlap && show_valid) begin
                    life_d   = 1'b1;
                    bvalid_d = 1'b0;
                    score_d  = (score_q >= SMAX) ? SMAX : score_q + 10'd1;
                    hold_d   = '0;
                    state_d  = S_HOLD;
                end else if (bx_e >= XLIM) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    bx_d = bx_q + STEP;
                end
            end
            S_HOLD: begin
                // The first HOLD cycle never exits, so the mover sees
                // at least one edge with life_state high.
                if ((!show_valid && hold_q != '0) || hold_q == HMAX) begin
                    life_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                life_d   = 1'b0;
                bvalid_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_22) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fire_q   <= 1'b0;
            life_q   <= 1'b0;
            bvalid_q <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
            score_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            fire_q   <= fire;
            life_q   <= life_d;
            bvalid_q <= bvalid_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            score_q  <= score_d;
            hold_q   <= hold_d;
        end
    end

    assign life_state = life_q;
    assign b_valid    = bvalid_q;
    assign b_x        = bx_q;
    assign b_y        = by_q;
    assign score      = score_q;

endmodule
